// File: rtl/down_counter.sv
// Ripple (asynchronous) binary down counter built from a chain of toggle stages.
// Latency: count settles WIDTH flop clock-to-q delays after each clk rising edge.
// Backpressure: none; free-running whenever reset is high, no enable or load.

// Single toggle stage: flips on every rising edge of its own clock.
module down_counter_stage (
    input  logic clk,
    input  logic rst_n,
    output logic q
);

    // Toggle on each rising edge; held at zero while reset is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= ~q;
        end
    end

endmodule

module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    // Clock for each stage. Stage 0 runs off clk; every higher stage runs off
    // the stage below it. A 0->1 transition of bit i-1 is a borrow out of the
    // lower bits when counting down, so the stage above must flip.
    logic [WIDTH-1:0] stage_clk;

    assign stage_clk[0] = clk;

    // Higher stage clocks come straight from the lower stage outputs. While
    // reset is low every output is forced to zero, so the only transitions on
    // these paths during reset are falling edges, which the stages ignore.
    // Release therefore produces no rising edge anywhere in the chain.
    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_clk
            assign stage_clk[i] = count[i-1];
        end
    endgenerate

    // One toggle flop per bit, all cleared asynchronously by reset.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage
            down_counter_stage u_stage (
                .clk   (stage_clk[i]),
                .rst_n (reset),
                .q     (count[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_down_counter.sv
// Randomized scoreboard bench for down_counter at WIDTH 4 and WIDTH 6.
// Expected values come from modular arithmetic on an integer model.
// A monitor process pops expectations and compares against both instances.
module tb_down_counter;

    logic       clk;
    logic       reset;
    logic [3:0] count4;
    logic [5:0] count6;

    down_counter #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .count (count4)
    );

    down_counter #(.WIDTH(6)) u_dut6 (
        .clk   (clk),
        .reset (reset),
        .count (count6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        time         t;
        int unsigned e4;
        int unsigned e6;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned m4;
    int unsigned m6;
    int          n_cmp;
    int          n_bad;
    bit          stim_done;

    // Push the current model value, to be checked at the current time.
    task automatic push(input string tag);
        exp_t e;
        e.t   = $time;
        e.e4  = m4;
        e.e6  = m6;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // One clk rising edge: model decrements mod 2^W while reset is high.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) begin
            m4 = (m4 + 16 - 1) % 16;
            m6 = (m6 + 64 - 1) % 64;
        end else begin
            m4 = 0;
            m6 = 0;
        end
        #1;
        push(tag);
    endtask

    // Drop reset between edges and check it clears without a clock edge.
    task automatic assert_reset(input string tag);
        #1;
        reset = 1'b0;
        m4 = 0;
        m6 = 0;
        #1;
        push(tag);
    endtask

    // Release reset mid low phase, away from any rising edge.
    task automatic release_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: compares each expectation at its scheduled time.
    initial begin
        exp_t e;
        forever begin
            wait (sb.size() != 0);
            e = sb[0];
            if (e.t > $time) #(e.t - $time);
            n_cmp++;
            if (int'(count4) != e.e4) begin
                n_bad++;
                $display("FAIL %s w4: got %0h expected %0h at %0t", e.tag, count4, e.e4, $time);
            end
            n_cmp++;
            if (int'(count6) != e.e6) begin
                n_bad++;
                $display("FAIL %s w6: got %0h expected %0h at %0t", e.tag, count6, e.e6, $time);
            end
            void'(sb.pop_front());
        end
    end

    // Stimulus: directed sequence from the plan, then random reset activity.
    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        stim_done = 1'b0;
        m4        = 0;
        m6        = 0;
        reset     = 1'b0;
        #1;
        push("por");
        tick("por_hold");
        tick("por_hold");

        // Release and run 20 edges: F..0 then wrap to F, E, D, C.
        release_reset();
        for (int i = 0; i < 20; i++) tick("wrap");

        // Reset mid-count after 10 edges, hold two clocks, release.
        assert_reset("rst_pre");
        release_reset();
        for (int i = 0; i < 10; i++) tick("mid_run");
        assert_reset("mid_rst");
        tick("mid_hold");
        tick("mid_hold");
        release_reset();
        tick("mid_first");

        // Short runs: 4 edges then reset, 8 edges then reset.
        assert_reset("short_rst");
        release_reset();
        for (int i = 0; i < 4; i++) tick("run4");
        assert_reset("run4_rst");
        release_reset();
        for (int i = 0; i < 8; i++) tick("run8");
        assert_reset("run8_rst");

        // Full WIDTH=6 period: 64 edges from release returns to zero.
        release_reset();
        for (int i = 0; i < 64; i++) tick("w6_period");

        // Random mix of counting, asynchronous resets and releases.
        for (int i = 0; i < 400; i++) begin
            if (reset) begin
                if ($urandom_range(0, 9) == 0) assert_reset("rnd_rst");
                else tick("rnd_run");
            end else begin
                if ($urandom_range(0, 2) == 0) release_reset();
                else tick("rnd_hold");
            end
        end
        stim_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then summarise.
    initial begin
        wait (stim_done);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            #1;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: stimulus not done at %0t, expected done", $time);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
